// File: rtl/pulse_period_monitor.sv
// Pulse period monitor: measures the spacing of single-cycle pulses,
// tracks lock against an expected period and counts lock losses.
//
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset
//   pulse_in      - pulse input, one event per high cycle
//   period        - last measured interval in clk cycles
//   period_valid  - strobe, period updated this cycle
//   locked        - high while the pulse train is locked
//   pulse_missing - strobe, expected pulse did not arrive in time
//   error_count   - saturating count of lock-loss events
module pulse_period_monitor #(
    parameter int unsigned EXPECTED   = 16,
    parameter int unsigned TOLERANCE  = 1,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             pulse_missing,
    output logic [15:0]      error_count
);

    localparam logic [CNT_W-1:0] LO = CNT_W'(EXPECTED - TOLERANCE);
    localparam logic [CNT_W-1:0] HI = CNT_W'(EXPECTED + TOLERANCE);
    localparam int unsigned GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    // good_cnt holds the number of matches already seen, so the
    // LOCK_COUNT-th match arrives while it equals LOCK_COUNT-1.
    localparam logic [GW-1:0] GOAL = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        LOCKED
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic             pv_q;
    logic             lk_q;
    logic             pm_q;
    logic [GW-1:0]    good_q;
    logic [15:0]      err_q;
    logic [15:0]      err_inc;
    logic             match;
    logic             timeout;

    always_comb begin
        match   = (cnt_q >= LO) && (cnt_q <= HI);
        // Only meaningful outside IDLE; the counter free-runs in IDLE.
        timeout = !pulse_in && (cnt_q == HI);
        if (pulse_in) begin
            cnt_d = CNT_W'(1);
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_inc = (&err_q) ? err_q : err_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            lk_q     <= 1'b0;
            pm_q     <= 1'b0;
            good_q   <= '0;
            err_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            pv_q  <= 1'b0;
            pm_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pulse_in) begin
                        state_q <= SEARCH;
                        good_q  <= '0;
                    end
                end
                SEARCH: begin
                    if (pulse_in) begin
                        period_q <= cnt_q;
                        pv_q     <= 1'b1;
                        if (!match) begin
                            good_q <= '0;
                        end else if (good_q == GOAL) begin
                            state_q <= LOCKED;
                            lk_q    <= 1'b1;
                            good_q  <= '0;
                        end else begin
                            good_q <= good_q + GW'(1);
                        end
                    end else if (timeout) begin
                        state_q <= IDLE;
                        pm_q    <= 1'b1;
                        good_q  <= '0;
                    end
                end
                LOCKED: begin
                    if (pulse_in) begin
                        period_q <= cnt_q;
                        pv_q     <= 1'b1;
                        if (!match) begin
                            state_q <= SEARCH;
                            lk_q    <= 1'b0;
                            good_q  <= '0;
                            err_q   <= err_inc;
                        end
                    end else if (timeout) begin
                        state_q <= IDLE;
                        lk_q    <= 1'b0;
                        pm_q    <= 1'b1;
                        good_q  <= '0;
                        err_q   <= err_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    lk_q    <= 1'b0;
                    good_q  <= '0;
                end
            endcase
        end
    end

    assign period        = period_q;
    assign period_valid  = pv_q;
    assign locked        = lk_q;
    assign pulse_missing = pm_q;
    assign error_count   = err_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Testbench for pulse_period_monitor: default instance driven through
// scenario tasks with a period scoreboard, plus an EXPECTED=1 instance.
module tb_pulse_period_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse = 1'b0;
    logic        pulse1 = 1'b0;

    logic [31:0] period;
    logic        period_valid;
    logic        locked;
    logic        pulse_missing;
    logic [15:0] error_count;

    logic [31:0] period1;
    logic        period_valid1;
    logic        locked1;
    logic        pulse_missing1;
    logic [15:0] error_count1;

    typedef struct {
        logic [31:0] per;
        logic        lk;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pm_seen = 0;

    always #5 clk = ~clk;

    pulse_period_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .pulse_in     (pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .pulse_missing(pulse_missing),
        .error_count  (error_count)
    );

    pulse_period_monitor #(
        .EXPECTED  (1),
        .TOLERANCE (0),
        .LOCK_COUNT(4),
        .CNT_W     (32)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .pulse_in     (pulse1),
        .period       (period1),
        .period_valid (period_valid1),
        .locked       (locked1),
        .pulse_missing(pulse_missing1),
        .error_count  (error_count1)
    );

    // One clock cycle of stimulus; any period_valid it produces is
    // popped from the scoreboard and compared.
    task automatic cyc(input logic p);
        exp_t e;
        pulse = p;
        @(posedge clk);
        #1;
        pulse = 1'b0;
        if (period_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: period_valid=1 period=%0d, required no strobe",
                         period);
            end else begin
                e = sb.pop_front();
                if (period !== e.per || locked !== e.lk) begin
                    miscompares++;
                    $display("FAIL sb_period: period=%0d locked=%0b, required period=%0d locked=%0b",
                             period, locked, e.per, e.lk);
                end
            end
        end
        if (pulse_missing) pm_seen++;
    endtask

    // Pulse gap cycles after the previous one.
    task automatic pul(input int gap, input bit pv, input bit lk);
        exp_t e;
        repeat (gap - 1) cyc(1'b0);
        if (pv) begin
            e.per = 32'(gap);
            e.lk  = lk;
            sb.push_back(e);
        end
        cyc(1'b1);
        if (pv) begin
            vectors++;
            if (sb.size() != 0) begin
                miscompares++;
                $display("FAIL sb_missing: period_valid=0, required strobe with period=%0d",
                         gap);
                sb.delete();
            end
        end
    endtask

    task automatic chk_err(input string name, input logic [15:0] exp);
        vectors++;
        if (error_count !== exp) begin
            miscompares++;
            $display("FAIL %s: error_count=%0d, required %0d", name, error_count, exp);
        end
    endtask

    task automatic chk_lock(input string name, input logic exp);
        vectors++;
        if (locked !== exp) begin
            miscompares++;
            $display("FAIL %s: locked=%0b, required %0b", name, locked, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        rst = 1'b0;
        vectors++;
        if ({period, period_valid, locked, pulse_missing, error_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_dut: per=%0d pv=%0b lk=%0b pm=%0b err=%0d, required all 0",
                     period, period_valid, locked, pulse_missing, error_count);
        end
        vectors++;
        if ({period1, period_valid1, locked1, pulse_missing1, error_count1} !== '0) begin
            miscompares++;
            $display("FAIL reset_dut1: per=%0d pv=%0b lk=%0b pm=%0b err=%0d, required all 0",
                     period1, period_valid1, locked1, pulse_missing1, error_count1);
        end
    endtask

    task automatic test_acquire;
        pul(10, 1'b0, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b1);
        chk_lock("acq_locked", 1'b1);
        chk_err("acq_err", 16'd0);
    endtask

    task automatic test_tolerance;
        pul(15, 1'b1, 1'b1);
        pul(17, 1'b1, 1'b1);
        chk_lock("tol_locked", 1'b1);
        chk_err("tol_err", 16'd0);
    endtask

    task automatic test_mismatch;
        pul(12, 1'b1, 1'b0);
        chk_lock("mis_unlock", 1'b0);
        chk_err("mis_err", 16'd1);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b1);
        chk_lock("mis_relock", 1'b1);
    endtask

    task automatic test_missing;
        int pm0;
        pm0 = pm_seen;
        repeat (16) cyc(1'b0);
        vectors++;
        if (pm_seen != pm0 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL miss_early: pm_count=%0d locked=%0b, required pm_count=%0d locked=1",
                     pm_seen - pm0, locked, 0);
        end
        cyc(1'b0);
        vectors++;
        if (pulse_missing !== 1'b1) begin
            miscompares++;
            $display("FAIL miss_strobe: pulse_missing=%0b, required 1", pulse_missing);
        end
        chk_lock("miss_unlock", 1'b0);
        chk_err("miss_err", 16'd2);
        cyc(1'b0);
        vectors++;
        if (pulse_missing !== 1'b0) begin
            miscompares++;
            $display("FAIL miss_oneshot: pulse_missing=%0b, required 0", pulse_missing);
        end
        pul(5, 1'b0, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b1);
        chk_lock("miss_relock", 1'b1);
    endtask

    task automatic test_reset_mid;
        pul(9, 1'b1, 1'b0);
        chk_err("rst_err_pre2", 16'd3);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b1);
        chk_err("rst_err_pre", 16'd3);
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        vectors++;
        if ({period, period_valid, locked, pulse_missing, error_count} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid: per=%0d pv=%0b lk=%0b pm=%0b err=%0d, required all 0",
                     period, period_valid, locked, pulse_missing, error_count);
        end
        pul(4, 1'b0, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b0);
        pul(16, 1'b1, 1'b1);
        chk_lock("rst_relock", 1'b1);
        chk_err("rst_err_post", 16'd0);
    endtask

    task automatic test_period_one;
        logic [31:0] eper;
        logic        epv;
        logic        elk;
        pulse1 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            epv  = (c >= 2);
            eper = epv ? 32'd1 : 32'd0;
            elk  = (c >= 5);
            vectors++;
            if (period_valid1 !== epv || period1 !== eper || locked1 !== elk) begin
                miscompares++;
                $display("FAIL p1_cycle%0d: pv=%0b per=%0d lk=%0b, required pv=%0b per=%0d lk=%0b",
                         c, period_valid1, period1, locked1, epv, eper, elk);
            end
        end
        pulse1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_acquire();
        test_tolerance();
        test_mismatch();
        test_missing();
        test_reset_mid();
        test_period_one();
        vectors++;
        if (pm_seen != 1) begin
            miscompares++;
            $display("FAIL pm_total: pulse_missing strobes=%0d, required 1", pm_seen);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
